// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signal bundle for the set-associative icache.
// The cache uses the slave modport; fetch plus memory together use master.
interface icache_assoc_if #(
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 4
);
  logic                                req_valid;
  logic [WORD_SIZE-1:0]                req_addr;
  logic                                flush;
  logic [WORD_SIZE-1:0]                instr;
  logic                                instr_valid;
  logic                                stall;
  logic                                mem_req;
  logic [WORD_SIZE-1:0]                mem_addr;
  logic                                mem_ready;
  logic [WORD_SIZE*WORDS_PER_LINE-1:0] mem_line;

  modport master (
    output req_valid, req_addr, flush, mem_ready, mem_line,
    input  instr, instr_valid, stall, mem_req, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, flush, mem_ready, mem_line,
    output instr, instr_valid, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_assoc.sv
// Parametrised set-associative instruction cache: 1-cycle hits, blocking line
// refill over a level request / pulse-ready handshake, per-set round-robin victims.
module icache_assoc #(
  parameter int                   WORD_SIZE      = 32,
  parameter int                   NUM_SETS       = 4,
  parameter int                   NUM_WAYS       = 2,
  parameter int                   WORDS_PER_LINE = 4,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR      = '0
) (
  input logic           clk,
  input logic           rst,
  icache_assoc_if.slave bus
);
  localparam int OFF_W   = $clog2(WORD_SIZE/8);
  localparam int WSEL_W  = $clog2(WORDS_PER_LINE);
  localparam int WS_IW   = (WSEL_W > 0) ? WSEL_W : 1;
  localparam int SET_W   = $clog2(NUM_SETS);
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int IDX_LSB = OFF_W + WSEL_W;
  localparam int TAG_W   = WORD_SIZE - IDX_LSB - SET_W;
  localparam int LINE_W  = WORD_SIZE * WORDS_PER_LINE;
  localparam logic [WORD_SIZE-1:0] LINE_MASK = WORD_SIZE'((64'd1 << IDX_LSB) - 64'd1);

  typedef enum logic [1:0] {IDLE, MISS, FLUSH} state_t;
  state_t state_q, state_d;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
  logic [NUM_SETS-1:0][WAY_W-1:0]    ptr_q;
  logic [TAG_W-1:0]                  tag_q  [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]                 data_q [NUM_SETS][NUM_WAYS];

  logic             flush_pending, flush_any;
  logic [SET_W-1:0] flush_cnt;
  logic [SET_W-1:0] req_set, fill_set;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [WS_IW-1:0] req_wsel;
  logic [NUM_WAYS-1:0] way_hit;
  logic             hit, fill, stall_c;
  logic [WORD_SIZE-1:0] hit_word;
  logic [WAY_W-1:0] victim;

  // mem_addr doubles as the latched miss address: set and tag of the fill come from it
  assign req_set  = bus.req_addr[IDX_LSB +: SET_W];
  assign req_tag  = bus.req_addr[WORD_SIZE-1 -: TAG_W];
  assign fill_set = bus.mem_addr[IDX_LSB +: SET_W];
  assign fill_tag = bus.mem_addr[WORD_SIZE-1 -: TAG_W];

  generate
    if (WSEL_W > 0) begin : g_wsel
      assign req_wsel = bus.req_addr[OFF_W +: WSEL_W];
    end else begin : g_no_wsel
      assign req_wsel = '0;
    end
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      assign way_hit[w] = valid_q[req_set][w] && (tag_q[req_set][w] == req_tag);
    end
  endgenerate

  assign hit       = bus.req_valid && (|way_hit);
  assign flush_any = flush_pending | bus.flush;
  assign fill      = (state_q == MISS) && bus.mem_ready;
  assign bus.stall = rst & stall_c;

  always_comb begin
    hit_word = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (way_hit[w]) hit_word = hit_word | data_q[req_set][w][req_wsel*WORD_SIZE +: WORD_SIZE];
  end

  // Descending scan so the lowest invalid way wins; pointer only when the set is full
  always_comb begin
    victim = ptr_q[fill_set];
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (!valid_q[fill_set][w]) victim = WAY_W'(w);
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_any) begin
          state_d = FLUSH;
          stall_c = 1'b1;
        end else if (bus.req_valid && !hit) begin
          state_d = MISS;
          stall_c = 1'b1;
        end
      end
      MISS: begin
        stall_c = 1'b1;
        if (bus.mem_ready) state_d = IDLE;
      end
      FLUSH: begin
        stall_c = 1'b1;
        if (flush_cnt == SET_W'(NUM_SETS-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      flush_pending   <= 1'b0;
      flush_cnt       <= '0;
      valid_q         <= '0;
      ptr_q           <= '0;
      bus.instr       <= NOP_INSTR;
      bus.instr_valid <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
    end else begin
      state_q         <= state_d;
      bus.instr_valid <= 1'b0;
      // a pulse landing on the last flush cycle re-arms another flush
      if (state_q == FLUSH && state_d == IDLE) flush_pending <= bus.flush;
      else if (bus.flush)                      flush_pending <= 1'b1;
      flush_cnt <= (state_q == FLUSH) ? flush_cnt + 1'b1 : '0;
      case (state_q)
        IDLE: if (!flush_any && bus.req_valid) begin
          if (hit) begin
            bus.instr       <= hit_word;
            bus.instr_valid <= 1'b1;
          end else begin
            bus.instr    <= NOP_INSTR;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= bus.req_addr & ~LINE_MASK;
          end
        end
        MISS: if (bus.mem_ready) begin
          bus.mem_req               <= 1'b0;
          valid_q[fill_set][victim] <= 1'b1;
          ptr_q[fill_set] <= (ptr_q[fill_set] == WAY_W'(NUM_WAYS-1)) ? '0 : ptr_q[fill_set] + 1'b1;
        end
        FLUSH: begin
          valid_q[flush_cnt] <= '0;
          ptr_q[flush_cnt]   <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_set][victim]  <= fill_tag;
      data_q[fill_set][victim] <= bus.mem_line;
    end
  end
endmodule
